// File: rtl/rf_pkg.sv
// Shared widths, types and constants for the rf_scb register file and scoreboard.
package rf_pkg;

   localparam int unsigned RF_DATA_W   = 32;
   localparam int unsigned RF_NUM_REGS = 32;
   localparam int unsigned RF_ADDR_W   = 5;

   typedef logic [RF_ADDR_W-1:0] regAddr_t;
   typedef logic [RF_DATA_W-1:0] regData_t;

   localparam regAddr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy bit per register, set at issue, cleared at writeback.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned NUM_REGS = RF_NUM_REGS,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     setValid,
   input  logic [ADDR_W-1:0]        setAddr,
   output logic                     setReady,
   input  logic                     clrValid,
   input  logic [ADDR_W-1:0]        clrAddr,
   input  logic [NUM_RD*ADDR_W-1:0] lookupAddr,
   output logic [NUM_RD-1:0]        lookupBusy,
   output logic [ADDR_W:0]          busyCount
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                set_fire, clr_fire, cnt_inc, cnt_dec;

   // A same-cycle writeback to the issued address frees it in time for the reissue.
   assign setReady = (setAddr == ZERO_ADDR) || !busy_q[setAddr] ||
                     (clrValid && (clrAddr == setAddr));

   assign set_fire = setValid && setReady && (setAddr != ZERO_ADDR);
   assign clr_fire = clrValid && (clrAddr != ZERO_ADDR);

   assign cnt_inc = set_fire && !busy_q[setAddr];
   assign cnt_dec = clr_fire && busy_q[clrAddr] && !(set_fire && (setAddr == clrAddr));

   always_comb begin
      busy_d = busy_q;
      if (clr_fire) busy_d[clrAddr] = 1'b0;
      // Set is applied last so it wins over a same-address clear.
      if (set_fire) busy_d[setAddr] = 1'b1;
   end

   always_comb begin
      count_d = count_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
      assign lookupBusy[i] = busy_q[lookupAddr[i*ADDR_W +: ADDR_W]];
   end

   assign busyCount = count_q;

endmodule

// File: rtl/rf_scb.sv
// Register file with one write port, NUM_RD combinational read ports and a pending-write
// scoreboard. Define RF_SCB_BYPASS_EN to forward writeback data to same-cycle reads.
module rf_scb
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned NUM_REGS = RF_NUM_REGS,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     regWrite,
   input  logic [ADDR_W-1:0]        writeAddr,
   input  logic [DATA_W-1:0]        dataIn,
   input  logic [NUM_RD*ADDR_W-1:0] readAddr,
   output logic [NUM_RD*DATA_W-1:0] dataOut,
   output logic [NUM_RD-1:0]        readBusy,
   input  logic                     issueValid,
   input  logic [ADDR_W-1:0]        issueAddr,
   output logic                     issueReady,
   output logic [ADDR_W:0]          busyCount
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("rf_scb: NUM_RD must be 1..4");
   end
   if (NUM_REGS < 2 || (1 << ADDR_W) != NUM_REGS) begin : g_bad_num_regs
      $error("rf_scb: NUM_REGS must be a power of two, at least 2");
   end

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [NUM_RD-1:0] lookup_busy;
   logic              wr_en;

   // Register 0 is never written, so its storage holds the reset value of zero.
   assign wr_en = regWrite && (writeAddr != ZERO_ADDR);

   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[writeAddr] = dataIn;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .ADDR_W   (ADDR_W)
   ) u_scoreboard (
      .clk        (clk),
      .rstN       (rstN),
      .setValid   (issueValid),
      .setAddr    (issueAddr),
      .setReady   (issueReady),
      .clrValid   (regWrite),
      .clrAddr    (writeAddr),
      .lookupAddr (readAddr),
      .lookupBusy (lookup_busy),
      .busyCount  (busyCount)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      logic              fwd_hit;

      assign rd_addr = readAddr[i*ADDR_W +: ADDR_W];
`ifdef RF_SCB_BYPASS_EN
      assign fwd_hit = wr_en && (writeAddr == rd_addr);
`else
      assign fwd_hit = 1'b0;
`endif
      assign dataOut[i*DATA_W +: DATA_W] = fwd_hit ? dataIn : regs_q[rd_addr];
      // A forwarded result is available now, so the read is no longer blocked.
      assign readBusy[i] = lookup_busy[i] & ~fwd_hit;
   end

endmodule

// File: tb/tb_rf_scb.sv
// Self-checking bench for rf_scb: array/popcount reference model plus directed vectors.
module tb_rf_scb;

   localparam int NRD = 2;
   localparam int AW  = 5;
   localparam int DW  = 32;

   logic              clk;
   logic              rstN;
   logic              regWrite;
   logic [AW-1:0]     writeAddr;
   logic [DW-1:0]     dataIn;
   logic [NRD*AW-1:0] readAddr;
   logic [NRD*DW-1:0] dataOut;
   logic [NRD-1:0]    readBusy;
   logic              issueValid;
   logic [AW-1:0]     issueAddr;
   logic              issueReady;
   logic [AW:0]       busyCount;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   rf_scb #(
      .DATA_W   (DW),
      .NUM_REGS (32),
      .NUM_RD   (NRD)
   ) dut (
      .clk        (clk),
      .rstN       (rstN),
      .regWrite   (regWrite),
      .writeAddr  (writeAddr),
      .dataIn     (dataIn),
      .readAddr   (readAddr),
      .dataOut    (dataOut),
      .readBusy   (readBusy),
      .issueValid (issueValid),
      .issueAddr  (issueAddr),
      .issueReady (issueReady),
      .busyCount  (busyCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain storage array and a bit per register for "pending".
   logic [DW-1:0] m_reg [32];
   logic [31:0]   m_busy;

   function automatic logic exp_ready();
      if (issueAddr == 0) return 1'b1;
      if (!m_busy[issueAddr]) return 1'b1;
      return regWrite && (writeAddr == issueAddr);
   endfunction

   function automatic logic [DW-1:0] exp_data(input int i);
      logic [AW-1:0] a;
      a = readAddr[i*AW +: AW];
      if (a == 0) return '0;
`ifdef RF_SCB_BYPASS_EN
      if (regWrite && writeAddr == a) return dataIn;
`endif
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input int i);
      logic [AW-1:0] a;
      a = readAddr[i*AW +: AW];
      if (a == 0) return 1'b0;
`ifdef RF_SCB_BYPASS_EN
      if (regWrite && writeAddr == a) return 1'b0;
`endif
      return m_busy[a];
   endfunction

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int r = 0; r < 32; r++) m_reg[r] <= '0;
         m_busy <= '0;
      end else begin
         if (regWrite && writeAddr != 0) begin
            m_reg[writeAddr]  <= dataIn;
            m_busy[writeAddr] <= 1'b0;
         end
         if (issueValid && exp_ready() && issueAddr != 0) m_busy[issueAddr] <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NRD; i++) begin
            check($sformatf("model dataOut%0d", i), 64'(dataOut[i*DW +: DW]), 64'(exp_data(i)));
            check($sformatf("model readBusy%0d", i), 64'(readBusy[i]), 64'(exp_busy(i)));
         end
         check("model issueReady", 64'(issueReady), 64'(exp_ready()));
         check("model busyCount", 64'(busyCount), 64'($countones(m_busy)));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int a, input int d);
      regWrite  = 1'b1;
      writeAddr = AW'(a);
      dataIn    = DW'(d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstN = 1'b1; regWrite = 1'b0; writeAddr = '0; dataIn = '0;
      readAddr = '0; issueValid = 1'b0; issueAddr = '0;
      #1 rstN = 1'b0;
      readAddr = {5'd31, 5'd0};
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("reset dataOut", 64'(dataOut), 64'd0);
      check("reset readBusy", 64'(readBusy), 64'd0);
      check("reset busyCount", 64'(busyCount), 64'd0);
      check("reset issueReady", 64'(issueReady), 64'd1);
      rstN = 1'b1;

      // Back-to-back writes, then read two of them together.
      set_wr(5, 879);  step();
      set_wr(2, 512);  step();
      set_wr(23, 6549); step();
      regWrite = 1'b0;
      readAddr = {5'd23, 5'd2};
      #1 check("read r2/r23", 64'(dataOut), {32'd6549, 32'd512});

      // Writes to r0 are dropped.
      set_wr(0, 77); step();
      regWrite = 1'b0;
      readAddr = {5'd0, 5'd5};
      #1 check("r0 reads zero", 64'(dataOut[63:32]), 64'd0);
      check("r5 kept", 64'(dataOut[31:0]), 64'd879);

      // Issue r5, then a WAW reissue must stall.
      issueValid = 1'b1; issueAddr = 5'd5;
      #1 check("issue r5 ready", 64'(issueReady), 64'd1);
      step();
      #1 check("r5 busy", 64'(readBusy[0]), 64'd1);
      check("count after issue", 64'(busyCount), 64'd1);
      check("waw stall", 64'(issueReady), 64'd0);
      step();
      issueValid = 1'b0;
      #1 check("count after stall", 64'(busyCount), 64'd1);

      // Writeback of r5 observed by a same-cycle read.
      set_wr(5, 36);
      #1;
`ifdef RF_SCB_BYPASS_EN
      check("bypass data", 64'(dataOut[31:0]), 64'd36);
      check("bypass busy", 64'(readBusy[0]), 64'd0);
`else
      check("no-bypass data", 64'(dataOut[31:0]), 64'd879);
      check("no-bypass busy", 64'(readBusy[0]), 64'd1);
`endif
      step();
      regWrite = 1'b0;
      #1 check("r5 after write", 64'(dataOut[31:0]), 64'd36);
      check("r5 cleared", 64'(readBusy[0]), 64'd0);
      check("count after clear", 64'(busyCount), 64'd0);

      // Retire and reissue r5 in the same cycle while it is busy.
      issueValid = 1'b1; issueAddr = 5'd5;
      step();
      set_wr(5, 99);
      #1 check("retire/reissue ready", 64'(issueReady), 64'd1);
      step();
      regWrite = 1'b0; issueValid = 1'b0;
      #1 check("r5 = 99", 64'(dataOut[31:0]), 64'd99);
      check("r5 busy again", 64'(readBusy[0]), 64'd1);
      check("count unchanged", 64'(busyCount), 64'd1);

      // Issue r7 and retire r5 in one cycle.
      issueValid = 1'b1; issueAddr = 5'd7;
      set_wr(5, 11);
      step();
      regWrite = 1'b0; issueValid = 1'b0;
      readAddr = {5'd7, 5'd5};
      #1 check("split busy", 64'(readBusy), 64'b10);
      check("split data", 64'(dataOut[31:0]), 64'd11);
      check("split count", 64'(busyCount), 64'd1);

      // Issue to r0 is accepted without effect.
      issueValid = 1'b1; issueAddr = 5'd0;
      #1 check("r0 issue ready", 64'(issueReady), 64'd1);
      step();
      #1 check("r0 issue count", 64'(busyCount), 64'd1);

      // Asynchronous reset between edges.
      issueAddr = 5'd3;
      step();
      issueValid = 1'b0;
      readAddr = {5'd23, 5'd3};
      #1 check("r3 busy", 64'(readBusy[0]), 64'd1);
      check("count 2", 64'(busyCount), 64'd2);
      rstN = 1'b0;
      #1 check("async rst busy", 64'(readBusy), 64'd0);
      check("async rst data", 64'(dataOut), 64'd0);
      check("async rst count", 64'(busyCount), 64'd0);
      check("async rst ready", 64'(issueReady), 64'd1);
      #3 rstN = 1'b1;
      issueValid = 1'b1;
      #1 check("post-rst ready", 64'(issueReady), 64'd1);
      step();
      issueValid = 1'b0;
      #1 check("post-rst count", 64'(busyCount), 64'd1);

      // Fill the scoreboard; r3 is already pending so its reissue stalls.
      for (int r = 1; r < 32; r++) begin
         issueValid = 1'b1; issueAddr = AW'(r);
         step();
      end
      issueValid = 1'b0;
      #1 check("count full", 64'(busyCount), 64'd31);

      // Retire everything with both read ports on the register being written.
      for (int r = 1; r < 32; r++) begin
         set_wr(r, r * 3 + 1);
         readAddr = {AW'(r), AW'(r)};
         step();
      end
      regWrite = 1'b0;
      readAddr = {5'd31, 5'd30};
      #1 check("count drained", 64'(busyCount), 64'd0);
      check("read r30/r31", 64'(dataOut), {32'd94, 32'd91});
      step();
      step();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
